// File: rtl/prog_cntr_seq_ctrl.sv
// Fetch-stage PC-mux sequencer with a circular return-address stack.
// Optional feature macro RAS_ERR_TRAP_EN: RAS overflow/underflow selects the TRAP mux input (code 5).
module prog_cntr_seq_ctrl #(
    parameter int                ADDR_W       = 14,
    parameter int                RAS_DEPTH    = 8,
    parameter int                FLUSH_CYCLES = 1,
    parameter logic [ADDR_W-1:0] TRAP_VEC     = 14'h0004
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] prog_cntr,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic              call,
    input  logic              ret,
    output logic [2:0]        sel_signals,
    output logic [ADDR_W-1:0] ret_addr,
    output logic              flush,
    output logic              ras_overflow,
    output logic              ras_underflow,
    output logic              illegal_ctrl
);

    localparam int               PTR_W   = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(RAS_DEPTH);
    localparam logic [2:0]       FLUSH_C = 3'(FLUSH_CYCLES);

    localparam logic [2:0] SEL_NEXT   = 3'd0;
    localparam logic [2:0] SEL_BRANCH = 3'd1;
    localparam logic [2:0] SEL_RET    = 3'd2;
    localparam logic [2:0] SEL_HOLD   = 3'd3;
    localparam logic [2:0] SEL_RSTVEC = 3'd4;
    localparam logic [2:0] SEL_TRAP   = 3'd5;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [2:0]        fcnt_r, fcnt_nxt_s;
    logic [ADDR_W-1:0] ras_r [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_r;
    logic [PTR_W-1:0]  top_idx_s;
    logic [PTR_W:0]    cnt_r;
    logic              empty_s, full_s;
    logic              push_s, pop_s, illegal_s;

    // The trap vector lives in the external mux; an out-of-range setup leaves this marker block.
    generate
        if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0) ||
            (FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 7) || ($bits(TRAP_VEC) != ADDR_W)) begin : g_illegal_config
        end
    endgenerate

    assign empty_s   = (cnt_r == '0);
    assign full_s    = (cnt_r == DEPTH_C);
    assign top_idx_s = ptr_r - {{(PTR_W-1){1'b0}}, 1'b1};
    assign ret_addr  = empty_s ? {ADDR_W{1'b0}} : ras_r[top_idx_s];

    // Next-state, mux select, flush and stack-request decode.
    always_comb begin
        state_nxt_s = state_r;
        fcnt_nxt_s  = fcnt_r;
        sel_signals = SEL_NEXT;
        flush       = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        illegal_s   = 1'b0;
        case (state_r)
            ST_BOOT: begin
                sel_signals = SEL_RSTVEC;
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (stall) begin
                    sel_signals = SEL_HOLD;
                end else if (ret) begin
`ifdef RAS_ERR_TRAP_EN
                    sel_signals = empty_s ? SEL_TRAP : SEL_RET;
`else
                    sel_signals = SEL_RET;
`endif
                    pop_s       = 1'b1;
                    illegal_s   = call | branch_taken;
                    fcnt_nxt_s  = FLUSH_C;
                    state_nxt_s = ST_FLUSH;
                end else if (call) begin
`ifdef RAS_ERR_TRAP_EN
                    sel_signals = full_s ? SEL_TRAP : SEL_BRANCH;
`else
                    sel_signals = SEL_BRANCH;
`endif
                    push_s      = 1'b1;
                    illegal_s   = branch_taken;
                    fcnt_nxt_s  = FLUSH_C;
                    state_nxt_s = ST_FLUSH;
                end else if (branch_taken) begin
                    sel_signals = SEL_BRANCH;
                    fcnt_nxt_s  = FLUSH_C;
                    state_nxt_s = ST_FLUSH;
                end else begin
                    sel_signals = SEL_NEXT;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (stall) begin
                    sel_signals = SEL_HOLD;
                end else if (fcnt_r <= 3'd1) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    fcnt_nxt_s = fcnt_r - 3'd1;
                end
            end
            default: begin
                sel_signals = SEL_RSTVEC;
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // Sequencer state and flush counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_BOOT;
            fcnt_r  <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            fcnt_r  <= fcnt_nxt_s;
        end
    end

    // Return-address stack; a push when full reuses the oldest slot because the pointer wraps onto it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_r[i] <= {ADDR_W{1'b0}};
            end
            ptr_r <= {PTR_W{1'b0}};
            cnt_r <= {(PTR_W+1){1'b0}};
        end else if (push_s) begin
            ras_r[ptr_r] <= prog_cntr + {{(ADDR_W-1){1'b0}}, 1'b1};
            ptr_r        <= ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            cnt_r        <= full_s ? cnt_r : cnt_r + {{PTR_W{1'b0}}, 1'b1};
        end else if (pop_s && !empty_s) begin
            ptr_r <= top_idx_s;
            cnt_r <= cnt_r - {{PTR_W{1'b0}}, 1'b1};
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            illegal_ctrl  <= 1'b0;
        end else begin
            ras_overflow  <= ras_overflow  | (push_s & full_s);
            ras_underflow <= ras_underflow | (pop_s & empty_s);
            illegal_ctrl  <= illegal_ctrl  | illegal_s;
        end
    end

endmodule
